// File: rtl/sd_pkg.sv
// Shared definitions for the SD CMD-line controller: frame lengths, the CRC7
// polynomial, response-type and FSM-state enums, and the index decoder.
package sd_pkg;

  localparam int FRAME_LEN_48  = 48;
  localparam int FRAME_LEN_136 = 136;
  // Start, transmission, index and argument bits: the span covered by CRC7.
  localparam int TX_DATA_BITS  = 40;

  // x^7 + x^3 + 1, with the x^7 term implied by the shift.
  localparam logic [6:0] CRC7_POLY = 7'h09;

  typedef enum logic [1:0] {
    RESP_NONE,
    RESP_48,
    RESP_48_NOCRC,
    RESP_136
  } resp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_RECV,
    ST_GAP
  } state_e;

  // Which response, if any, the card returns for a given command index.
  function automatic resp_e resp_type(input logic [5:0] index);
    case (index)
      6'd0, 6'd4, 6'd15: return RESP_NONE;
      6'd2, 6'd9, 6'd10: return RESP_136;
      6'd41:             return RESP_48_NOCRC;
      default:           return RESP_48;
    endcase
  endfunction

  // One serial CRC7 step, message bit entering at the top.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator. iclr restarts from zero in the same cycle that ien
// may already feed the first bit; with ien low the value holds so it can be
// read out bit by bit.
module sd_crc7
  import sd_pkg::*;
(
  input  logic       iclk,
  input  logic       irst_n,
  input  logic       iclr,
  input  logic       ien,
  input  logic       ibit,
  output logic [6:0] ocrc
);

  logic [6:0] crc_q;
  logic [6:0] crc_d;
  logic [6:0] crc_base;

  // Next CRC: optional clear, then optional one-bit update.
  always_comb begin
    crc_base = iclr ? 7'h00 : crc_q;
    crc_d    = ien ? crc7_step(crc_base, ibit) : crc_base;
  end

  // CRC register.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      crc_q <= 7'h00;
    end else begin
      // NOTE: clocked state uses non-blocking assignment so every flop samples pre-edge values.
      crc_q <= crc_d;
    end
  end

  assign ocrc = crc_q;

endmodule

// File: rtl/sd_cmd_ctrl.sv
// SD bus CMD-line controller: serialises one 48-bit command per istart, then
// collects the card response (48 or 136 bits) and reports done/error status.
// One iclk cycle is one CMD-line bit.
// Build option: define SD_CMD_CRC_CHECK_EN to check the CRC7 of received
// 48-bit responses; otherwise only transmission and end bits are checked.
module sd_cmd_ctrl
  import sd_pkg::*;
#(
  parameter int RESP_TIMEOUT = 64,
  parameter int NRC_GAP      = 8
) (
  input  logic        iclk,
  input  logic        irst_n,
  input  logic        istart,
  input  logic [5:0]  iindex,
  input  logic [31:0] iarg,
  input  logic        icmd_in,
  output logic        ocmd_out,
  output logic        ocmd_oe,
  output logic [31:0] oresp,
  output logic        odone,
  output logic        otimeout,
  output logic        ocrc_fail,
  output logic        obusy
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] SEND_LAST  = CNT_W'(FRAME_LEN_48 - 1);
  localparam logic [CNT_W-1:0] CRC_FIRST  = CNT_W'(TX_DATA_BITS);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(RESP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(NRC_GAP - 1);
  // RECV counts the bits after the start bit; the last one is the end bit.
  localparam logic [CNT_W-1:0] RX48_LAST  = CNT_W'(FRAME_LEN_48 - 2);
  localparam logic [CNT_W-1:0] RX136_LAST = CNT_W'(FRAME_LEN_136 - 2);

  state_e            state_q,    state_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic [38:0]       tx_sh_q,    tx_sh_d;
  logic [38:0]       rx_sh_q,    rx_sh_d;
  resp_e             rtype_q,    rtype_d;
  logic              tbit_err_q, tbit_err_d;
  logic              cmd_out_q,  cmd_out_d;
  logic              cmd_oe_q,   cmd_oe_d;
  logic [31:0]       resp_q,     resp_d;
  logic              done_q,     done_d;
  logic              timeout_q,  timeout_d;
  logic              crc_fail_q, crc_fail_d;

  logic [CNT_W-1:0]  nb;
  logic [CNT_W-1:0]  rx_last;
  logic [2:0]        crc_sel;
  logic              tx_crc_clr;
  logic              tx_crc_en;
  logic              tx_crc_bit;
  logic [6:0]        tx_crc;
  logic              crc_bad;

  // Transmit CRC7 over the first 40 frame bits, fed as each bit is launched.
  sd_crc7 u_tx_crc (
    .iclk   (iclk),
    .irst_n (irst_n),
    .iclr   (tx_crc_clr),
    .ien    (tx_crc_en),
    .ibit   (tx_crc_bit),
    .ocrc   (tx_crc)
  );

`ifdef SD_CMD_CRC_CHECK_EN
  // Received bit 8 is the last CRC-covered bit; it arrives at this RECV count.
  localparam logic [CNT_W-1:0] RX_CRC_LAST = CNT_W'(TX_DATA_BITS - 2);

  logic       rx_crc_clr;
  logic       rx_crc_en;
  logic [6:0] rx_crc;

  // Receive CRC starts on the start bit and covers bits 47..8 of the response.
  assign rx_crc_clr = (state_q == ST_WAIT) && !icmd_in;
  assign rx_crc_en  = rx_crc_clr || ((state_q == ST_RECV) && (cnt_q <= RX_CRC_LAST));

  sd_crc7 u_rx_crc (
    .iclk   (iclk),
    .irst_n (irst_n),
    .iclr   (rx_crc_clr),
    .ien    (rx_crc_en),
    .ibit   (icmd_in),
    .ocrc   (rx_crc)
  );

  // At the end bit rx_sh_q[6:0] holds received bits 7..1, the CRC field.
  assign crc_bad = (rtype_q == RESP_48) && (rx_crc != rx_sh_q[6:0]);
`else
  assign crc_bad = 1'b0;
`endif

  // Next-state, frame sequencing and response capture.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rtype_d    = rtype_q;
    tbit_err_d = tbit_err_q;
    cmd_out_d  = 1'b1;
    cmd_oe_d   = 1'b0;
    resp_d     = resp_q;
    done_d     = 1'b0;
    timeout_d  = timeout_q;
    crc_fail_d = crc_fail_q;
    tx_crc_clr = 1'b0;
    tx_crc_en  = 1'b0;
    tx_crc_bit = 1'b0;
    nb         = cnt_q + CNT_W'(1);
    crc_sel    = 3'd6 - nb[2:0];
    rx_last    = (rtype_q == RESP_136) ? RX136_LAST : RX48_LAST;

    case (state_q)
      ST_IDLE: begin
        if (istart) begin
          // Launch the start bit now; the rest of the frame waits in tx_sh.
          state_d    = ST_SEND;
          cnt_d      = '0;
          tx_sh_d    = {1'b1, iindex, iarg};
          rtype_d    = resp_type(iindex);
          cmd_out_d  = 1'b0;
          cmd_oe_d   = 1'b1;
          timeout_d  = 1'b0;
          crc_fail_d = 1'b0;
          tx_crc_clr = 1'b1;
          tx_crc_en  = 1'b1;
          tx_crc_bit = 1'b0;
        end
      end

      ST_SEND: begin
        if (cnt_q == SEND_LAST) begin
          // End bit has been on the line for a cycle; release the pad.
          cnt_d   = '0;
          state_d = (rtype_q == RESP_NONE) ? ST_GAP : ST_WAIT;
        end else begin
          cnt_d    = nb;
          cmd_oe_d = 1'b1;
          if (nb < CRC_FIRST) begin
            cmd_out_d  = tx_sh_q[38];
            tx_sh_d    = {tx_sh_q[37:0], 1'b0};
            tx_crc_en  = 1'b1;
            tx_crc_bit = tx_sh_q[38];
          end else if (nb < SEND_LAST) begin
            cmd_out_d = tx_crc[crc_sel];
          end else begin
            cmd_out_d = 1'b1;
          end
        end
      end

      ST_WAIT: begin
        if (!icmd_in) begin
          state_d    = ST_RECV;
          cnt_d      = '0;
          rx_sh_d    = {rx_sh_q[37:0], icmd_in};
          tbit_err_d = 1'b0;
        end else if (cnt_q == TO_LAST) begin
          state_d   = ST_GAP;
          cnt_d     = '0;
          timeout_d = 1'b1;
          resp_d    = '0;
        end else begin
          cnt_d = nb;
        end
      end

      ST_RECV: begin
        rx_sh_d = {rx_sh_q[37:0], icmd_in};
        if ((cnt_q == '0) && icmd_in) begin
          tbit_err_d = 1'b1;
        end
        if (cnt_q == rx_last) begin
          // icmd_in is the end bit; rx_sh_q[38:7] are response bits 39..8.
          state_d    = ST_GAP;
          cnt_d      = '0;
          resp_d     = rx_sh_q[38:7];
          crc_fail_d = tbit_err_q || !icmd_in || crc_bad;
        end else begin
          cnt_d = nb;
        end
      end

      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = nb;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, datapath and registered pad/status outputs.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      // NOTE: datapath registers reset with the control state so no output can show X after reset.
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rtype_q    <= RESP_NONE;
      tbit_err_q <= 1'b0;
      cmd_out_q  <= 1'b1;
      cmd_oe_q   <= 1'b0;
      resp_q     <= '0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      crc_fail_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rtype_q    <= rtype_d;
      tbit_err_q <= tbit_err_d;
      cmd_out_q  <= cmd_out_d;
      cmd_oe_q   <= cmd_oe_d;
      resp_q     <= resp_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      crc_fail_q <= crc_fail_d;
    end
  end

  assign ocmd_out  = cmd_out_q;
  assign ocmd_oe   = cmd_oe_q;
  assign oresp     = resp_q;
  assign odone     = done_q;
  assign otimeout  = timeout_q;
  assign ocrc_fail = crc_fail_q;
  assign obusy     = (state_q != ST_IDLE);

endmodule
